// File: rtl/dmem_arbiter_if.sv
// CPU, debug and memory-side signal bundle for dmem_arbiter.
// slave = arbiter view; master = the CPU/debug/memory environment around it.
interface dmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_lock;
  logic          dbg_gnt;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_rvalid;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  mem_rdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output mem_rdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU (MEM stage) vs debug port, 0-cycle grant, 1-cycle load return.
// Define DMEM_ARB_LOCK_EN to let dbg_lock hold the memory for debug bursts (LOCKED state).
module dmem_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic       {NORMAL, LOCKED} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_e;

  state_e        state_q;
  logic [WW-1:0] wait_q, wait_d;
  owner_e        rd_owner_q, rd_owner_d;

  logic locked, starved, cpu_gnt, dbg_gnt;

  always_comb begin
    locked  = (state_q == LOCKED);
    starved = (wait_q == WW'(MAX_WAIT));
    // Reset suppresses every grant so requests are ignored while rst is low.
    dbg_gnt = rst && bus.dbg_req && (locked || !bus.cpu_req || starved);
    cpu_gnt = rst && bus.cpu_req && !locked && !dbg_gnt;
  end

  always_comb begin
    wait_d = wait_q;
    if (locked || !bus.dbg_req || dbg_gnt) begin
      wait_d = '0;
    end else if (!starved) begin
      wait_d = wait_q + WW'(1);
    end

    rd_owner_d = OWN_NONE;
    if (cpu_gnt && !bus.cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (dbg_gnt && !bus.dbg_we) begin
      rd_owner_d = OWN_DBG;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= NORMAL;
      wait_q     <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      wait_q     <= wait_d;
      rd_owner_q <= rd_owner_d;
`ifdef DMEM_ARB_LOCK_EN
      case (state_q)
        NORMAL:  if (dbg_gnt && bus.dbg_lock) state_q <= LOCKED;
        LOCKED:  if (!bus.dbg_lock)           state_q <= NORMAL;
        default:                              state_q <= NORMAL;
      endcase
`else
      state_q <= NORMAL;
`endif
    end
  end

`ifndef DMEM_ARB_LOCK_EN
  logic unused_dbg_lock;
  assign unused_dbg_lock = bus.dbg_lock;
`endif

  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.cpu_stall = rst && bus.cpu_req && !cpu_gnt;

  assign bus.mem_en    = cpu_gnt || dbg_gnt;
  assign bus.mem_we    = cpu_gnt ? bus.cpu_we    : (dbg_gnt && bus.dbg_we);
  assign bus.mem_addr  = dbg_gnt ? bus.dbg_addr  : bus.cpu_addr;
  assign bus.mem_wdata = dbg_gnt ? bus.dbg_wdata : bus.cpu_wdata;

  // Gating with rst kills a return that was in flight when reset hit.
  assign bus.cpu_rvalid = rst && (rd_owner_q == OWN_CPU);
  assign bus.dbg_rvalid = rst && (rd_owner_q == OWN_DBG);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dbg_rdata  = bus.mem_rdata;

endmodule
